// File: rtl/io_bridge.sv
// I/O-side bridge: turns single-word io_* requests into one Avalon-MM master transaction.
// A watchdog finishes any stalled transaction with io_fault so the core never hangs.
module io_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        io_start,
    input  logic        io_write,
    input  logic [29:0] io_addr,
    input  logic [31:0] io_data_wr,
    output logic        io_ready,
    output logic [31:0] io_data_rd,
    output logic        io_fault,
    output logic [31:0] avl_address,
    output logic        avl_read,
    output logic        avl_write,
    output logic [31:0] avl_writedata,
    output logic [3:0]  avl_byteenable,
    input  logic        avl_waitrequest,
    input  logic [31:0] avl_readdata,
    input  logic        avl_readdatavalid
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWaitRd,
        StDone
    } state_e;

    localparam logic [15:0] WdLast = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] WdMax  = 16'hFFFF;

    state_e      state;
    logic [15:0] wd_cnt;

    logic wd_expired;
    logic wr_done;
    logic rd_accept;
    logic rd_done_req;
    logic rd_done_wait;

    assign wd_expired   = (wd_cnt == WdLast);
    assign wr_done      = avl_write && !avl_waitrequest;
    assign rd_accept    = avl_read && !avl_waitrequest;
    // Zero-latency slave: data arrives in the acceptance cycle.
    assign rd_done_req  = rd_accept && avl_readdatavalid;
    assign rd_done_wait = avl_readdatavalid;

    assign avl_byteenable = 4'b1111;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= StIdle;
            wd_cnt        <= '0;
            avl_read      <= 1'b0;
            avl_write     <= 1'b0;
            avl_address   <= '0;
            avl_writedata <= '0;
            io_ready      <= 1'b0;
            io_fault      <= 1'b0;
            io_data_rd    <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (io_start) begin
                        avl_address   <= {io_addr, 2'b00};
                        avl_writedata <= io_data_wr;
                        avl_write     <= io_write;
                        avl_read      <= !io_write;
                        wd_cnt        <= '0;
                        state         <= StReq;
                    end
                end

                StReq: begin
                    if (wd_cnt != WdMax) begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
                    // A completion in the expiry cycle takes priority over the fault.
                    if (wr_done) begin
                        avl_write <= 1'b0;
                        io_ready  <= 1'b1;
                        state     <= StDone;
                    end else if (rd_done_req) begin
                        avl_read   <= 1'b0;
                        io_data_rd <= avl_readdata;
                        io_ready   <= 1'b1;
                        state      <= StDone;
                    end else if (wd_expired) begin
                        avl_read   <= 1'b0;
                        avl_write  <= 1'b0;
                        io_data_rd <= '0;
                        io_ready   <= 1'b1;
                        io_fault   <= 1'b1;
                        state      <= StDone;
                    end else if (rd_accept) begin
                        avl_read <= 1'b0;
                        state    <= StWaitRd;
                    end
                end

                StWaitRd: begin
                    if (wd_cnt != WdMax) begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
                    if (rd_done_wait) begin
                        io_data_rd <= avl_readdata;
                        io_ready   <= 1'b1;
                        state      <= StDone;
                    end else if (wd_expired) begin
                        io_data_rd <= '0;
                        io_ready   <= 1'b1;
                        io_fault   <= 1'b1;
                        state      <= StDone;
                    end
                end

                StDone: begin
                    io_ready <= 1'b0;
                    io_fault <= 1'b0;
                    state    <= StIdle;
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/io_bridge.md
Name: io_bridge

Overview:
- Downstream stage on the I/O side of the load/store address decoder. It consumes the io_start/io_write/io_addr/io_data_wr requests for addresses outside the first 512 MiB and returns io_ready/io_data_rd.
- It converts each single-word request into one Avalon-MM master transaction on the external peripheral bus.
- A watchdog completes any stalled transaction with a fault, so the core never hangs on an absent peripheral.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles a transaction may spend in REQ+WAIT_RD before it is aborted. Range 1..65535.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- io_start  in  1  request strobe; sampled only in IDLE
- io_write  in  1  1 = write, 0 = read; sampled with io_start
- io_addr  in  30 (ptr)  word address; sampled with io_start
- io_data_wr  in  32 (word)  write data; sampled with io_start
- io_ready  out  1  one-cycle completion pulse
- io_data_rd  out  32 (word)  read data; valid in the io_ready cycle, held afterwards
- io_fault  out  1  high only with io_ready when the transaction timed out
- avl_address  out  32  byte address = {io_addr, 2'b00}
- avl_read  out  1  Avalon read request
- avl_write  out  1  Avalon write request
- avl_writedata  out  32  write data
- avl_byteenable  out  4  always 4'b1111
- avl_waitrequest  in  1  slave stall
- avl_readdata  in  32  read data
- avl_readdatavalid  in  1  read data strobe

Behaviour:
- Reset values (all outputs registered):
  - state = IDLE.
  - avl_read, avl_write, io_ready, io_fault = 0.
  - io_data_rd, avl_address, avl_writedata = 0.
  - Watchdog counter = 0.
- IDLE:
  - io_start=1 latches address, data and direction into the avl_* registers.
  - Sets avl_read or avl_write on the next edge, clears the counter, and goes to REQ.
  - io_start=0 keeps the state.
  - Stray avl_readdatavalid is ignored.
- REQ:
  - avl_read/avl_write, avl_address and avl_writedata are held stable while avl_waitrequest=1.
  - Write with waitrequest=0: deassert avl_write, go to DONE.
  - Read with waitrequest=0: deassert avl_read, go to WAIT_RD.
  - If avl_readdatavalid arrives in the same cycle as the read is accepted (zero-latency slave): capture avl_readdata and go directly to DONE.
- WAIT_RD:
  - avl_readdatavalid=1 captures avl_readdata into io_data_rd and goes to DONE.
- DONE:
  - io_ready=1 for exactly one cycle, then IDLE.
  - io_data_rd is unchanged for writes.
- Watchdog:
  - The counter increments every cycle in REQ or WAIT_RD.
  - When counter == TIMEOUT_CYCLES-1 and no completion occurs that cycle: drop avl_read/avl_write, set io_data_rd = 0, and go to DONE with io_fault=1.
  - A completion in the same cycle as expiry wins: normal result, io_fault=0.
  - The counter saturates and never wraps.
- Latency:
  - io_start at cycle N gives avl_read/avl_write high at N+1.
  - Acceptance (write) or readdatavalid (read) at cycle M gives io_ready at M+1.
  - Minimum write round trip: io_ready at N+2.
  - Minimum read round trip: io_ready at N+2 (zero-latency slave) or N+3.
- io_start outside IDLE:
  - Ignored; this is a protocol violation with no side effects.
  - The upstream decoder guarantees one outstanding request.
- io_ready is never high outside DONE. Upstream logic relies on io_ready=0 while busy.
- Reset mid-transaction:
  - Returns to IDLE with the bus request dropped immediately (asynchronous).
  - A late avl_readdatavalid after reset is ignored.

Test Plan:
- Read, waitrequest=0, readdatavalid 2 cycles after acceptance, readdata=0xCAFE0001, io_addr=0x2000_0010:
  - avl_address=0x8000_0040.
  - io_ready pulses once with io_data_rd=0xCAFE0001 and io_fault=0.
  - io_data_rd is held after the pulse.
- Write io_addr=0x3FFF_FFFF, data=0x1234_5678, waitrequest high for 5 cycles:
  - avl_write/address/data stable for all 6 cycles.
  - io_ready exactly 1 cycle after acceptance.
  - io_data_rd unchanged.
- TIMEOUT_CYCLES=8, read with waitrequest stuck at 1:
  - avl_read drops after 8 cycles in REQ.
  - io_ready=1, io_fault=1, io_data_rd=0.
  - Next read completes normally with io_fault=0.
- Zero-latency slave (readdatavalid in the acceptance cycle, data 0xA5A5A5A5):
  - io_ready at N+2, data 0xA5A5A5A5.
  - No WAIT_RD visit.
- io_start pulses during REQ, plus stray avl_readdatavalid in IDLE:
  - No extra Avalon request.
  - No extra io_ready pulse.
  - io_data_rd unchanged.
- rst_n asserted while in WAIT_RD:
  - All outputs at reset values immediately.
  - A subsequent readdatavalid produces no io_ready.
